// File: rtl/ctrl_pipe_if.sv
// rtl/ctrl_pipe_if.sv - control-pipeline stimulus and per-stage observation bundle
interface ctrl_pipe_if #(
  parameter int WIDTH  = 23,
  parameter int STAGES = 4
);
  logic [WIDTH-1:0]        in_ctrl;
  logic                    in_valid;
  logic                    in_branch;
  logic [STAGES-1:0]       stall;
  logic [STAGES-1:0]       flush;
  logic                    exc_flush;
  logic [STAGES*WIDTH-1:0] stage_ctrl;
  logic [STAGES-1:0]       stage_valid;
  logic [STAGES-1:0]       stage_ds;

  modport master (
    output in_ctrl, in_valid, in_branch, stall, flush, exc_flush,
    input  stage_ctrl, stage_valid, stage_ds
  );

  modport slave (
    input  in_ctrl, in_valid, in_branch, stall, flush, exc_flush,
    output stage_ctrl, stage_valid, stage_ds
  );
endinterface

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - staged control-word pipeline with stall/flush/exception clear; delay-slot tracking under CTRL_PIPE_DSLOT_EN
module ctrl_pipe #(
  parameter int WIDTH     = 23,
  parameter int STAGES    = 4,
  parameter int EXC_STAGE = 2
) (
  input logic        clk,
  input logic        rst,
  ctrl_pipe_if.slave bus
);

  logic [WIDTH-1:0]  ctrl_q   [STAGES];
  logic [WIDTH-1:0]  src_ctrl [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] stall_up;
  logic [STAGES-1:0] exc_mask;
  logic [STAGES-1:0] clr;
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] bub;

  // Decode the per-stage action: clear beats hold, hold beats bubble, else load.
  always_comb begin
    stall_up = bus.stall << 1;
    exc_mask = '0;
    for (int i = 0; i < STAGES; i++) begin
      exc_mask[i] = (i <= EXC_STAGE);
    end
    clr  = bus.flush | (exc_mask & {STAGES{bus.exc_flush}});
    hold = ~clr & bus.stall;
    bub  = ~clr & ~bus.stall & stall_up;
  end

  // Upstream source for each stage; a non-valid instruction never carries control bits.
  always_comb begin
    src_ctrl[0]  = bus.in_valid ? bus.in_ctrl : '0;
    src_valid    = '0;
    src_valid[0] = bus.in_valid;
    for (int i = 1; i < STAGES; i++) begin
      src_ctrl[i]  = ctrl_q[i-1];
      src_valid[i] = valid_q[i-1];
    end
  end

  // Stage registers for ctrl and valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < STAGES; i++) begin
        ctrl_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (clr[i] || bub[i]) begin
          ctrl_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end else if (!hold[i]) begin
          ctrl_q[i]  <= src_ctrl[i];
          valid_q[i] <= src_valid[i];
        end
      end
    end
  end

`ifdef CTRL_PIPE_DSLOT_EN
  logic              br_last;
  logic [STAGES-1:0] ds_q;
  logic [STAGES-1:0] src_ds;

  // Stage 0 is in a delay slot when the last real instruction it loaded was a branch.
  always_comb begin
    src_ds    = '0;
    src_ds[0] = bus.in_valid & br_last;
    for (int i = 1; i < STAGES; i++) begin
      src_ds[i] = ds_q[i-1];
    end
  end

  // Branch memory: only real instructions loaded into stage 0 update it, so bubbles keep it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      br_last <= 1'b0;
    end else if (clr[0]) begin
      br_last <= 1'b0;
    end else if (!hold[0] && bus.in_valid) begin
      br_last <= bus.in_branch;
    end
  end

  // Per-stage delay-slot flags follow the same clear/hold/bubble/load rules as ctrl.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (clr[i] || bub[i]) begin
          ds_q[i] <= 1'b0;
        end else if (!hold[i]) begin
          ds_q[i] <= src_ds[i];
        end
      end
    end
  end

  // Delay-slot flags straight from the registers.
  always_comb begin
    bus.stage_ds = ds_q;
  end
`else
  logic dslot_unused;
  assign dslot_unused = bus.in_branch;

  // Without delay-slot tracking no stage is ever in a slot.
  always_comb begin
    bus.stage_ds = '0;
  end
`endif

  // Outputs come straight from the stage registers.
  always_comb begin
    bus.stage_ctrl  = '0;
    for (int i = 0; i < STAGES; i++) begin
      bus.stage_ctrl[i*WIDTH +: WIDTH] = ctrl_q[i];
    end
    bus.stage_valid = valid_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - table-driven scoreboard bench for ctrl_pipe
module tb_ctrl_pipe;
  localparam int W = 23;
  localparam int S = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  ctrl_pipe_if #(.WIDTH(W), .STAGES(S)) bus ();

  ctrl_pipe #(.WIDTH(W), .STAGES(S), .EXC_STAGE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string          name;
    logic [W-1:0]   ctrl;
    logic           valid;
    logic           branch;
    logic [S-1:0]   stall;
    logic [S-1:0]   flush;
    logic           exc;
    logic [S-1:0]   e_valid;
    logic [W-1:0]   e_c0;
    logic [W-1:0]   e_c1;
    logic [W-1:0]   e_c3;
    logic [S-1:0]   e_ds;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(string name, logic [W-1:0] ctrl, logic valid, logic branch,
                     logic [S-1:0] stall, logic [S-1:0] flush, logic exc,
                     logic [S-1:0] e_valid, logic [W-1:0] e_c0, logic [W-1:0] e_c1,
                     logic [W-1:0] e_c3, logic [S-1:0] e_ds);
    vec_t v;
    v.name = name; v.ctrl = ctrl; v.valid = valid; v.branch = branch;
    v.stall = stall; v.flush = flush; v.exc = exc;
    v.e_valid = e_valid; v.e_c0 = e_c0; v.e_c1 = e_c1; v.e_c3 = e_c3; v.e_ds = e_ds;
    vecs.push_back(v);
  endtask

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] sc(int k);
    return bus.stage_ctrl[k*W +: W];
  endfunction

  task automatic drive(logic [W-1:0] ctrl, logic valid, logic branch,
                       logic [S-1:0] stall, logic [S-1:0] flush, logic exc);
    bus.in_ctrl   = ctrl;
    bus.in_valid  = valid;
    bus.in_branch = branch;
    bus.stall     = stall;
    bus.flush     = flush;
    bus.exc_flush = exc;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t  v;
    logic [S-1:0] eds;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    drive('0, 1'b0, 1'b0, '0, '0, 1'b0);

    //   name                ctrl     v  b  stall    flush    exc  e_valid  c0       c1       c3       ds
    add("stream1",          23'h1,   1, 0, 4'b0000, 4'b0000, 0, 4'b0001, 23'h1,   23'h0,   23'h0,   4'b0000);
    add("stream2",          23'h2,   1, 0, 4'b0000, 4'b0000, 0, 4'b0011, 23'h2,   23'h1,   23'h0,   4'b0000);
    add("stream3",          23'h3,   1, 0, 4'b0000, 4'b0000, 0, 4'b0111, 23'h3,   23'h2,   23'h0,   4'b0000);
    add("stream4",          23'h4,   1, 0, 4'b0000, 4'b0000, 0, 4'b1111, 23'h4,   23'h3,   23'h1,   4'b0000);
    add("load2a",           23'h2A,  1, 0, 4'b0000, 4'b0000, 0, 4'b1111, 23'h2A,  23'h4,   23'h2,   4'b0000);
    add("stall_bub1",       23'h55,  1, 0, 4'b0001, 4'b0000, 0, 4'b1101, 23'h2A,  23'h0,   23'h3,   4'b0000);
    add("stall_bub2",       23'h55,  1, 0, 4'b0001, 4'b0000, 0, 4'b1001, 23'h2A,  23'h0,   23'h4,   4'b0000);
    add("release",          23'h55,  1, 0, 4'b0000, 4'b0000, 0, 4'b0011, 23'h55,  23'h2A,  23'h0,   4'b0000);
    add("refill6",          23'h6,   1, 0, 4'b0000, 4'b0000, 0, 4'b0111, 23'h6,   23'h55,  23'h0,   4'b0000);
    add("refill7",          23'h7,   1, 0, 4'b0000, 4'b0000, 0, 4'b1111, 23'h7,   23'h6,   23'h2A,  4'b0000);
    add("exc_flush",        23'h8,   1, 0, 4'b1000, 4'b0000, 1, 4'b1000, 23'h0,   23'h0,   23'h2A,  4'b0000);
    add("refill9",          23'h9,   1, 0, 4'b0000, 4'b0000, 0, 4'b0001, 23'h9,   23'h0,   23'h0,   4'b0000);
    add("refillA",          23'hA,   1, 0, 4'b0000, 4'b0000, 0, 4'b0011, 23'hA,   23'h9,   23'h0,   4'b0000);
    add("flush_over_stall", 23'hB,   1, 0, 4'b0010, 4'b0010, 0, 4'b0001, 23'hB,   23'h0,   23'h0,   4'b0000);
    add("invalid_in",       23'h7FFFFF, 0, 0, 4'b0000, 4'b0000, 0, 4'b0010, 23'h0, 23'hB,  23'h0,   4'b0000);
    add("branch",           23'h10,  1, 1, 4'b0000, 4'b0000, 0, 4'b0101, 23'h10,  23'h0,   23'h0,   4'b0000);
    add("bubble_after_br",  23'h11,  0, 0, 4'b0000, 4'b0000, 0, 4'b1010, 23'h0,   23'h10,  23'hB,   4'b0000);
    add("slot",             23'h12,  1, 0, 4'b0000, 4'b0000, 0, 4'b0101, 23'h12,  23'h0,   23'h0,   4'b0001);
    add("branch2",          23'h13,  1, 1, 4'b0000, 4'b0000, 0, 4'b1011, 23'h13,  23'h12,  23'h10,  4'b0010);
    add("flush0",           23'h14,  1, 0, 4'b0000, 4'b0001, 0, 4'b0110, 23'h0,   23'h13,  23'h0,   4'b0100);
    add("post_flush",       23'h15,  1, 0, 4'b0000, 4'b0000, 0, 4'b1101, 23'h15,  23'h0,   23'h12,  4'b1000);
    add("br_stall",         23'h16,  1, 1, 4'b0000, 4'b0000, 0, 4'b1011, 23'h16,  23'h15,  23'h13,  4'b0000);
    add("stall0",           23'h17,  1, 0, 4'b0001, 4'b0000, 0, 4'b0101, 23'h16,  23'h0,   23'h0,   4'b0000);
    add("slot_after_stall", 23'h17,  1, 0, 4'b0000, 4'b0000, 0, 4'b1011, 23'h17,  23'h16,  23'h15,  4'b0001);

    // reset state, observed asynchronously
    #1;
    check("reset_ctrl",  bus.stage_ctrl,  '0);
    check("reset_valid", bus.stage_valid, '0);
    check("reset_ds",    bus.stage_ds,    '0);

    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      v = vecs[i];
      drive(v.ctrl, v.valid, v.branch, v.stall, v.flush, v.exc);
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      v = exp_q.pop_front();
`ifdef CTRL_PIPE_DSLOT_EN
      eds = v.e_ds;
`else
      eds = '0;
`endif
      check({v.name, "_valid"}, bus.stage_valid, v.e_valid);
      check({v.name, "_c0"},    sc(0),           v.e_c0);
      check({v.name, "_c1"},    sc(1),           v.e_c1);
      check({v.name, "_c3"},    sc(3),           v.e_c3);
      check({v.name, "_ds"},    bus.stage_ds,    eds);
    end

    // fill the pipeline, then drop reset between edges
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      drive(23'h21 + W'(k), 1'b1, 1'b1, '0, '0, 1'b0);
    end
    @(posedge clk);
    #1;
    check("full_valid", bus.stage_valid, 4'b1111);
    check("full_c3",    sc(3),           23'h21);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_ctrl",  bus.stage_ctrl,  '0);
    check("async_rst_valid", bus.stage_valid, '0);
    check("async_rst_ds",    bus.stage_ds,    '0);

    // first edge after release loads normally; cleared branch memory means no slot
    @(negedge clk);
    rst = 1'b1;
    drive(23'h30, 1'b1, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    check("post_rst_valid", bus.stage_valid, 4'b0001);
    check("post_rst_c0",    sc(0),           23'h30);
    check("post_rst_ds",    bus.stage_ds,    '0);

    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
